sdm_adc_rx: RTL and testbench

- Sigma-delta ADC receive path. It is the capture-side counterpart of the DAC chain and runs on the PLL-generated global clock.
- It samples an external comparator (LVDS input pair) and drives the 1-bit feedback back to the RC integrator.
- It decimates the bitstream with a 3rd-order CIC filter and emits unsigned PCM words with a single-cycle valid strobe.

---
 rtl/sdm_adc_rx.sv | 99 +++++++++
 tb/tb_sdm_adc_rx.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sdm_adc_rx.sv
// Sigma-delta ADC receive path: comparator sync, 1-bit feedback, 3rd-order CIC
// decimator and unsigned PCM output with a one-cycle valid strobe.
module sdm_adc_rx #(
   parameter int DECIM = 256,
   parameter int OUT_W = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             CMP_IN,
   input  logic             ENABLE,
   output logic             FB_OUT,
   output logic [OUT_W-1:0] DATA,
   output logic             VALID,
   output logic             OVR
);

   localparam int LOG2D = $clog2(DECIM);
   localparam int FSW   = 3 * LOG2D;
   localparam int CW    = FSW + 1;

   logic             sync1;
   logic             samp;
   logic [LOG2D-1:0] cnt;
   logic [CW-1:0]    i1, i2, i3;
   logic [CW-1:0]    d1, d2, d3;
   logic [1:0]       settle;

   logic             tick;
   logic [CW-1:0]    c1, c2, c3;
   logic             sat;
   logic [FSW-1:0]   clamped;
   logic [OUT_W-1:0] data_next;

   // A tick only exists on an enabled cycle, so ENABLE falling on it discards it.
   assign tick = ENABLE && (cnt == LOG2D'(DECIM - 1));

   always_comb begin
      c1        = i3 - d1;
      c2        = c1 - d2;
      c3        = c2 - d3;
      sat       = c3[CW-1];
      clamped   = sat ? '1 : c3[FSW-1:0];
      data_next = OUT_W'(clamped >> (FSW - OUT_W));
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sync1  <= 1'b0;
         samp   <= 1'b0;
         FB_OUT <= 1'b0;
         cnt    <= '0;
         i1     <= '0;
         i2     <= '0;
         i3     <= '0;
         d1     <= '0;
         d2     <= '0;
         d3     <= '0;
         settle <= '0;
         DATA   <= '0;
         VALID  <= 1'b0;
         OVR    <= 1'b0;
      end else begin
         sync1  <= CMP_IN;
         samp   <= sync1;
         // Feedback runs regardless of ENABLE so the analog loop never opens.
         FB_OUT <= samp;
         VALID  <= 1'b0;
         if (!ENABLE) begin
            cnt    <= '0;
            i1     <= '0;
            i2     <= '0;
            i3     <= '0;
            d1     <= '0;
            d2     <= '0;
            d3     <= '0;
            settle <= '0;
         end else begin
            i1  <= i1 + {{(CW-1){1'b0}}, samp};
            i2  <= i2 + i1;
            i3  <= i3 + i2;
            cnt <= cnt + LOG2D'(1);
            if (tick) begin
               d1 <= i3;
               d2 <= c1;
               d3 <= c2;
               // The first three ticks only fill the comb delays.
               if (settle != 2'd3) begin
                  settle <= settle + 2'd1;
               end else begin
                  DATA  <= data_next;
                  VALID <= 1'b1;
                  if (sat) OVR <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sdm_adc_rx.sv
// Directed bench for sdm_adc_rx: reset, feedback delay, CIC output levels,
// valid spacing, enable pause and mid-frame reset.
module tb_sdm_adc_rx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmp_in;
   logic        enable;
   logic        fb_out;
   logic [15:0] data;
   logic        valid;
   logic        ovr;

   int          total = 0;
   int          bad   = 0;
   int          mode  = 0;
   int          phase = 0;
   int          n;
   logic [15:0] rnd_pat = 16'hB2C5;
   logic        hist [4];

   always #5 clk = ~clk;

   sdm_adc_rx #(.DECIM(256), .OUT_W(16)) dut (
      .CLK    (clk),
      .RESET  (rst_n),
      .CMP_IN (cmp_in),
      .ENABLE (enable),
      .FB_OUT (fb_out),
      .DATA   (data),
      .VALID  (valid),
      .OVR    (ovr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // mode: 0 zeros, 1 ones, 2 alternating, 3 one-in-four, 4 irregular
   function automatic logic pat_bit(input int m, input int p);
      logic [1:0] q;
      logic [3:0] k;
      q = p[1:0];
      k = p[3:0];
      case (m)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return p[0];
         3:       return (q == 2'd0);
         default: return rnd_pat[k];
      endcase
   endfunction

   // Advance to the next falling edge (outputs sampled there) and drive the next bit.
   task automatic step();
      logic b;
      @(negedge clk);
      phase++;
      b = pat_bit(mode, phase);
      cmp_in  = b;
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = b;
   endtask

   task automatic wait_valid(input int max_steps, output int steps);
      steps = -1;
      for (int k = 1; k <= max_steps; k++) begin
         step();
         if (valid === 1'b1) begin
            steps = k;
            break;
         end
      end
   endtask

   task automatic run_level(input int m, input logic [15:0] exp_data, input logic exp_ovr,
                            input string tag);
      int s;
      mode   = m;
      enable = 1'b0;
      step();
      check({tag, "_valid_while_off"}, {31'd0, valid}, 32'd0);
      enable = 1'b1;
      wait_valid(1100, s);
      check({tag, "_first_latency"}, s, 32'd1024);
      check({tag, "_data1"}, {16'd0, data}, {16'd0, exp_data});
      check({tag, "_ovr1"}, {31'd0, ovr}, {31'd0, exp_ovr});
      wait_valid(300, s);
      check({tag, "_spacing"}, s, 32'd256);
      check({tag, "_data2"}, {16'd0, data}, {16'd0, exp_data});
      step();
      check({tag, "_pulse_width"}, {31'd0, valid}, 32'd0);
   endtask

   initial begin
      for (int k = 0; k < 4; k++) hist[k] = 1'b0;
      rst_n  = 1'b0;
      enable = 1'b0;
      cmp_in = 1'b0;
      mode   = 4;

      repeat (6) step();
      check("rst_fb", {31'd0, fb_out}, 32'd0);
      check("rst_data", {16'd0, data}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_ovr", {31'd0, ovr}, 32'd0);

      rst_n = 1'b1;
      repeat (3) step();
      for (int k = 0; k < 8; k++) begin
         step();
         check("fb_delay", {31'd0, fb_out}, {31'd0, hist[3]});
      end

      run_level(0, 16'h0000, 1'b0, "zero");
      run_level(2, 16'h8000, 1'b0, "half");
      run_level(3, 16'h4000, 1'b0, "quarter");
      run_level(1, 16'hFFFF, 1'b1, "full");

      repeat (100) step();
      enable = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         check("pause_valid", {31'd0, valid}, 32'd0);
         check("pause_data", {16'd0, data}, 32'h0000FFFF);
      end
      enable = 1'b1;
      wait_valid(1100, n);
      check("pause_restart_latency", n, 32'd1024);
      check("pause_ovr_sticky", {31'd0, ovr}, 32'd1);

      repeat (50) step();
      rst_n = 1'b0;
      #1;
      check("midrst_data", {16'd0, data}, 32'd0);
      check("midrst_valid", {31'd0, valid}, 32'd0);
      check("midrst_ovr", {31'd0, ovr}, 32'd0);
      step();
      rst_n = 1'b1;
      wait_valid(1100, n);
      check("midrst_latency", n, 32'd1024);
      check("midrst_data_full", {16'd0, data}, 32'h0000FFFF);
      check("midrst_ovr_again", {31'd0, ovr}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
